ifu_fetch: RTL and testbench

Instruction-fetch stage directly downstream of the PC generator. It takes the current PC, issues one request at a time to instruction memory over a valid/ready handshake, and pairs each returned instruction word with its PC. Pairs are buffered in a small FIFO and presented to the decode stage over valid/ready. A redirect from execute flushes all in-flight and buffered fetches.

---
 rtl/ifu_fetch.sv | 144 ++++++++++++++
 tb/tb_ifu_fetch.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: issues one imem request at a time and pairs each
// returned word with its PC. Pairs are buffered in a small FIFO toward decode.
module ifu_fetch #(
  parameter int unsigned CPU_WIDTH  = 64,
  parameter int unsigned INST_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pc_ena,
  input  logic [CPU_WIDTH-1:0]  pc_in,
  input  logic                  pc_no_use,
  input  logic                  flush,
  output logic                  fetch_stall,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [CPU_WIDTH-1:0]  imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [INST_WIDTH-1:0] imem_resp_data,
  output logic                  if_valid,
  input  logic                  if_ready,
  output logic [CPU_WIDTH-1:0]  if_pc,
  output logic [INST_WIDTH-1:0] if_inst
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [CPU_WIDTH-1:0]  req_pc;
  logic                  discard;

  logic [CPU_WIDTH-1:0]  fifo_pc   [FIFO_DEPTH];
  logic [INST_WIDTH-1:0] fifo_inst [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      fifo_count;

  logic                  outstanding;
  logic [CNT_W-1:0]      occupancy;
  logic                  space;
  logic                  can_issue;
  logic                  resp_hit;
  logic                  push;
  logic                  pop;

  // A slot is reserved while a request is in flight, so a push never overflows.
  assign outstanding = (state != IDLE);
  assign occupancy   = fifo_count + CNT_W'(outstanding);
  assign space       = (occupancy < CNT_W'(FIFO_DEPTH));

  assign can_issue = ~rst & pc_ena & ~pc_no_use & ~flush & space &
                     ((state == IDLE) | ((state == WAIT) & imem_resp_valid));

  assign resp_hit = (state == WAIT) & imem_resp_valid;
  assign push     = resp_hit & ~discard & ~flush;
  assign pop      = if_valid & if_ready & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (can_issue) state_nxt = REQ;
      REQ:  if (imem_req_ready) state_nxt = WAIT;
      WAIT: if (imem_resp_valid) state_nxt = can_issue ? REQ : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    imem_req_valid = (state == REQ);
    imem_req_addr  = {req_pc[CPU_WIDTH-1:2], 2'b00};
    fetch_stall    = ~can_issue;
  end

  // A flush cannot cancel a request already in flight; its response is
  // marked for dropping instead, unless it lands in the flush cycle itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_pc  <= '0;
      discard <= 1'b0;
    end else begin
      if (can_issue) begin
        req_pc <= pc_in;
      end
      if (resp_hit) begin
        discard <= 1'b0;
      end else if (flush && outstanding) begin
        discard <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc[i]   <= '0;
        fifo_inst[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        fifo_pc[wr_ptr]   <= req_pc;
        fifo_inst[wr_ptr] <= imem_resp_data;
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_comb begin
    if_valid = (fifo_count != '0);
    if_pc    = fifo_pc[rd_ptr];
    if_inst  = fifo_inst[rd_ptr];
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: transaction-level model (queue of fetched pairs plus
// one in-flight request record) checked every cycle, plus directed pins.
module tb_ifu_fetch;

  localparam int CW = 64;
  localparam int IW = 32;
  localparam int D  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          pc_ena;
  logic [CW-1:0] pc_in;
  logic          pc_no_use;
  logic          flush;
  logic          fetch_stall;
  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [CW-1:0] imem_req_addr;
  logic          imem_resp_valid;
  logic [IW-1:0] imem_resp_data;
  logic          if_valid;
  logic          if_ready;
  logic [CW-1:0] if_pc;
  logic [IW-1:0] if_inst;

  ifu_fetch #(
    .CPU_WIDTH (CW),
    .INST_WIDTH(IW),
    .FIFO_DEPTH(D)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_ena         (pc_ena),
    .pc_in          (pc_in),
    .pc_no_use      (pc_no_use),
    .flush          (flush),
    .fetch_stall    (fetch_stall),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_inst        (if_inst)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Instruction memory contents: a fixed function of the word address.
  function automatic logic [31:0] inst_of(input logic [63:0] a);
    logic [31:0] w;
    w = a[31:0] & 32'hFFFF_FFFC;
    return w ^ 32'h1357_9BDF ^ {w[15:0], w[31:16]};
  endfunction

  // Stimulus state
  logic          d_rst, d_pc_ena, d_pc_no_use, d_flush, d_if_ready, d_req_ready;
  logic [CW-1:0] pc_cur;
  logic [CW-1:0] redirect_pc;
  logic [CW-1:0] pend_addr;
  int            pend_cnt = 0;
  int            lat_fix  = 1;

  task step();
    @(negedge clk);
    rst             = d_rst;
    pc_ena          = d_pc_ena;
    pc_no_use       = d_pc_no_use;
    flush           = d_flush;
    if_ready        = d_if_ready;
    imem_req_ready  = d_req_ready;
    pc_in           = pc_cur;
    imem_resp_valid = 1'b0;
    imem_resp_data  = $urandom;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = inst_of(pend_addr);
      end
    end
    #3;
    if (!d_rst && imem_req_valid && imem_req_ready) begin
      pend_cnt  = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 3));
      pend_addr = imem_req_addr;
    end
    if (d_flush) pc_cur = redirect_pc;
    else if (!d_rst && !fetch_stall) pc_cur = pc_cur + 64'd4;
  endtask

  // Reference model: fetched pairs awaiting decode, plus the one in-flight request.
  logic [CW+IW-1:0] mq[$];
  logic             m_out  = 1'b0;
  logic             m_acc  = 1'b0;
  logic             m_dead = 1'b0;
  logic [CW-1:0]    m_pc   = '0;

  initial begin : compare
    logic exp_can, resp_hit, mpush, mpop;
    logic [CW+IW-1:0] head;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        check("rst_stall", fetch_stall, 1);
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_req_addr", imem_req_addr, 0);
        check("rst_if_valid", if_valid, 0);
        check("rst_if_pc", if_pc, 0);
        check("rst_if_inst", if_inst, 0);
        mq.delete();
        m_out  = 1'b0;
        m_acc  = 1'b0;
        m_dead = 1'b0;
        continue;
      end
      exp_can = pc_ena && !pc_no_use && !flush &&
                ((mq.size() + int'(m_out)) < D) &&
                (!m_out || (m_acc && imem_resp_valid));
      check("fetch_stall", fetch_stall, !exp_can);
      check("req_valid", imem_req_valid, m_out && !m_acc);
      if (m_out && !m_acc) check("req_addr", imem_req_addr, {m_pc[CW-1:2], 2'b00});
      check("if_valid", if_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        head = mq[0];
        check("if_pc", if_pc, head[CW+IW-1:IW]);
        check("if_inst", if_inst, head[IW-1:0]);
      end
      resp_hit = m_out && m_acc && imem_resp_valid;
      mpush    = resp_hit && !m_dead && !flush;
      mpop     = (mq.size() != 0) && if_ready && !flush;
      if (flush) mq.delete();
      else begin
        if (mpop) void'(mq.pop_front());
        if (mpush) mq.push_back({m_pc, inst_of(m_pc)});
      end
      if (resp_hit) begin
        m_out  = 1'b0;
        m_dead = 1'b0;
      end else if (m_out && flush) begin
        m_dead = 1'b1;
      end
      if (m_out && !m_acc && imem_req_ready) m_acc = 1'b1;
      if (exp_can) begin
        m_out  = 1'b1;
        m_acc  = 1'b0;
        m_pc   = pc_in;
        m_dead = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    bit found;
    rst = 1'b1; pc_ena = 1'b0; pc_in = '0; pc_no_use = 1'b0; flush = 1'b0;
    if_ready = 1'b0; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    d_rst = 1'b1; d_pc_ena = 1'b0; d_pc_no_use = 1'b0; d_flush = 1'b0;
    d_if_ready = 1'b0; d_req_ready = 1'b0;
    pc_cur = 64'h8000_0000; redirect_pc = 64'h8000_0100; pend_addr = '0;
    repeat (3) step();

    // Zero-wait memory, decode always ready
    d_rst = 1'b0; d_pc_ena = 1'b1; d_if_ready = 1'b1; d_req_ready = 1'b1; lat_fix = 1;
    step();
    check("a_issue0", fetch_stall, 0);
    step();
    check("a_req_valid", imem_req_valid, 1);
    check("a_req_addr", imem_req_addr, 64'h8000_0000);
    check("a_stall_req", fetch_stall, 1);
    step();
    check("a_issue1", fetch_stall, 0);
    step();
    check("a_if_valid", if_valid, 1);
    check("a_if_pc", if_pc, 64'h8000_0000);
    check("a_if_inst", if_inst, 32'h9357_1BDF);

    d_rst = 1'b1;
    repeat (2) step();

    // Decode stalled: two entries buffer up, no third request
    d_rst = 1'b0; d_if_ready = 1'b0; pc_cur = 64'h8000_0000;
    repeat (11) step();
    check("b_stall", fetch_stall, 1);
    check("b_no_req", imem_req_valid, 0);
    check("b_if_valid", if_valid, 1);
    check("b_head0", if_pc, 64'h8000_0000);
    d_if_ready = 1'b1;
    step();
    check("b_pop0", if_pc, 64'h8000_0000);
    step();
    check("b_pop1", if_pc, 64'h8000_0004);
    check("b_resume", fetch_stall, 0);
    step();
    check("b_req_valid", imem_req_valid, 1);
    check("b_req_addr", imem_req_addr, 64'h8000_0008);

    // Reset while waiting on a slow response; the late response must be ignored
    lat_fix = 3;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (pend_cnt == 3) found = 1;
    end
    check("c_reach_wait", found, 1);
    d_rst = 1'b1;
    step();
    check("c_rst_req_valid", imem_req_valid, 0);
    check("c_rst_if_valid", if_valid, 0);
    check("c_rst_stall", fetch_stall, 1);
    d_rst = 1'b0; d_pc_ena = 1'b0;
    repeat (6) step();
    check("c_stale_ignored", if_valid, 0);
    check("c_idle", imem_req_valid, 0);

    // Randomized traffic: stalls, holes in the PC stream, redirects
    lat_fix = 0;
    pc_cur  = 64'h8000_0000;
    for (int c = 0; c < 3000; c++) begin
      d_pc_ena    = ($urandom_range(0, 19) != 0);
      d_pc_no_use = ($urandom_range(0, 9) == 0);
      d_flush     = ($urandom_range(0, 14) == 0);
      d_if_ready  = ($urandom_range(0, 9) < 6);
      d_req_ready = ($urandom_range(0, 9) < 6);
      redirect_pc = ($urandom_range(0, 3) == 0) ? 64'h8000_0100 : {$urandom, $urandom};
      step();
    end

    @(negedge clk);
    #4;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
